// File: rtl/pipe_skid_reg_if.sv
// Valid/ready payload channel used on both sides of pipe_skid_reg.
// master drives valid/data, slave drives ready.
interface pipe_skid_reg_if #(
   parameter int unsigned DATA_W = 141
);
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;

   modport master (
      output valid,
      output data,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      output ready
   );
endinterface

// File: rtl/pipe_skid_reg.sv
// Generic pipeline boundary register with valid/ready handshake,
// optional one-entry skid buffer and a bubble performance counter.
module pipe_skid_reg #(
   parameter int unsigned       DATA_W    = 141,
   parameter logic [DATA_W-1:0] NOP_VALUE = '0,
   parameter bit                SKID_EN   = 1'b1,
   parameter int unsigned       CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   pipe_skid_reg_if.slave    up,
   pipe_skid_reg_if.master   dn,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  bubble_cnt
);

   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic [1:0]        occ_q, occ_d;
   logic              rdy_q, rdy_d;
   logic [CNT_W-1:0]  bub_q, bub_d;
   logic              out_valid;
   logic              in_ready;
   logic              acc;
   logic              dep;

   assign out_valid = (occ_q != 2'd0);
   // Skid mode: ready comes straight from a flop, never from dn.ready.
   assign in_ready  = SKID_EN ? rdy_q : (!out_valid || dn.ready);
   assign acc       = up.valid && in_ready;
   assign dep       = out_valid && dn.ready;

   assign up.ready   = in_ready;
   assign dn.valid   = out_valid;
   assign dn.data    = main_q;
   assign occupancy  = occ_q;
   assign bubble_cnt = bub_q;

   // Next-state: entries kept at NOP_VALUE whenever they are not live.
   always_comb begin
      main_d = main_q;
      skid_d = skid_q;
      occ_d  = occ_q;
      if (flush) begin
         main_d = NOP_VALUE;
         skid_d = NOP_VALUE;
         occ_d  = 2'd0;
      end else begin
         unique case (occ_q)
            2'd0: begin
               if (acc) begin
                  main_d = up.data;
                  occ_d  = 2'd1;
               end
            end
            2'd1: begin
               if (acc && dep) begin
                  main_d = up.data;
               end else if (acc) begin
                  skid_d = up.data;
                  occ_d  = 2'd2;
               end else if (dep) begin
                  main_d = NOP_VALUE;
                  occ_d  = 2'd0;
               end
            end
            2'd2: begin
               if (dep) begin
                  main_d = skid_q;
                  skid_d = NOP_VALUE;
                  occ_d  = 2'd1;
               end
            end
            default: begin
               main_d = NOP_VALUE;
               skid_d = NOP_VALUE;
               occ_d  = 2'd0;
            end
         endcase
      end
      rdy_d = (occ_d != 2'd2);
   end

   // Saturating count of cycles where downstream could take but had nothing.
   always_comb begin
      bub_d = bub_q;
      if (!out_valid && dn.ready && !(&bub_q)) begin
         bub_d = bub_q + 1'b1;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_q <= NOP_VALUE;
         skid_q <= NOP_VALUE;
         occ_q  <= 2'd0;
         rdy_q  <= 1'b1;
         bub_q  <= '0;
      end else begin
         main_q <= main_d;
         skid_q <= skid_d;
         occ_q  <= occ_d;
         rdy_q  <= rdy_d;
         bub_q  <= bub_d;
      end
   end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_pipe_skid_reg;

   localparam int DW = 141;
   localparam int SW = 16;
   localparam logic [SW-1:0] S_NOP = 16'h5A5A;
   localparam int MMAX = 65535;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic m_flush, s_flush, t_flush;
   logic [1:0] m_occ, s_occ, t_occ;
   logic [15:0] m_bub, s_bub;
   logic [3:0] t_bub;

   int tests = 0;
   int fails = 0;

   logic [DW-1:0] mq[$];
   int mcnt = 0;

   always #5 clk = ~clk;

   pipe_skid_reg_if #(.DATA_W(DW)) m_in();
   pipe_skid_reg_if #(.DATA_W(DW)) m_out();
   pipe_skid_reg_if #(.DATA_W(SW)) s_in();
   pipe_skid_reg_if #(.DATA_W(SW)) s_out();
   pipe_skid_reg_if #(.DATA_W(SW)) t_in();
   pipe_skid_reg_if #(.DATA_W(SW)) t_out();

   pipe_skid_reg #(.DATA_W(DW)) u_main (
      .clk(clk), .rst(rst_n), .flush(m_flush),
      .up(m_in), .dn(m_out),
      .occupancy(m_occ), .bubble_cnt(m_bub)
   );

   pipe_skid_reg #(
      .DATA_W(SW), .NOP_VALUE(S_NOP), .SKID_EN(1'b0)
   ) u_single (
      .clk(clk), .rst(rst_n), .flush(s_flush),
      .up(s_in), .dn(s_out),
      .occupancy(s_occ), .bubble_cnt(s_bub)
   );

   pipe_skid_reg #(.DATA_W(SW), .CNT_W(4)) u_sat (
      .clk(clk), .rst(rst_n), .flush(t_flush),
      .up(t_in), .dn(t_out),
      .occupancy(t_occ), .bubble_cnt(t_bub)
   );

   function automatic logic [DW-1:0] rnd_data();
      logic [159:0] w;
      w = {$urandom, $urandom, $urandom, $urandom, $urandom};
      return w[DW-1:0];
   endfunction

   function automatic logic [DW-1:0] m_head();
      if (mq.size() != 0) return mq[0];
      return '0;
   endfunction

   // Advance one clock; the model of u_main steps with the same inputs.
   task automatic cyc();
      bit mv, acc, dep;
      mv  = (mq.size() != 0);
      acc = m_in.valid && (mq.size() < 2);
      dep = mv && m_out.ready;
      if (m_flush) begin
         mq.delete();
      end else begin
         if (dep) void'(mq.pop_front());
         if (acc) mq.push_back(m_in.data);
      end
      if (!mv && m_out.ready && mcnt < MMAX) mcnt++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      m_in.valid = 1'b1;
      m_in.data = DW'(16'h1234);
      m_out.ready = 1'b1;
      m_flush = 1'b0;
      s_in.valid = 1'b0; s_in.data = '0;
      s_out.ready = 1'b0; s_flush = 1'b0;
      t_in.valid = 1'b0; t_in.data = '0;
      t_out.ready = 1'b0; t_flush = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (m_out.valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_valid: got %b want 0", m_out.valid);
      end
      tests++;
      if (m_out.data !== '0) begin
         fails++;
         $display("FAIL reset_data: got %h want 0", m_out.data);
      end
      tests++;
      if (m_occ !== 2'd0) begin
         fails++;
         $display("FAIL reset_occ: got %0d want 0", m_occ);
      end
      tests++;
      if (m_bub !== 16'd0 || t_bub !== 4'd0) begin
         fails++;
         $display("FAIL reset_bub: got %0d/%0d want 0/0", m_bub, t_bub);
      end
      tests++;
      if (s_out.data !== S_NOP) begin
         fails++;
         $display("FAIL reset_nop: got %h want %h", s_out.data, S_NOP);
      end
      m_in.valid = 1'b0;
      rst_n = 1'b1;
      mq.delete();
      mcnt = 0;
      #1;
      tests++;
      if (m_in.ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_ready: got %b want 1", m_in.ready);
      end
   endtask

   task automatic test_stream();
      m_out.ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         m_in.valid = 1'b1;
         m_in.data = DW'(i);
         cyc();
         tests++;
         if (m_out.valid !== 1'b1 || m_out.data !== DW'(i)) begin
            fails++;
            $display("FAIL stream_data[%0d]: got %b/%h want 1/%h",
                     i, m_out.valid, m_out.data, DW'(i));
         end
         tests++;
         if (m_occ !== 2'd1 || m_in.ready !== 1'b1) begin
            fails++;
            $display("FAIL stream_occ[%0d]: got occ %0d rdy %b want 1 1",
                     i, m_occ, m_in.ready);
         end
      end
      m_in.valid = 1'b0;
      cyc();
      tests++;
      if (m_out.valid !== 1'b0 || m_out.data !== '0) begin
         fails++;
         $display("FAIL stream_drain: got %b/%h want 0/0",
                  m_out.valid, m_out.data);
      end
   endtask

   task automatic test_skid();
      logic [DW-1:0] a, b, c;
      a = rnd_data(); b = rnd_data(); c = rnd_data();
      m_out.ready = 1'b1;
      m_in.valid = 1'b1;
      m_in.data = a;
      cyc();
      tests++;
      if (m_out.data !== a) begin
         fails++;
         $display("FAIL skid_a: got %h want %h", m_out.data, a);
      end
      m_out.ready = 1'b0;
      m_in.data = b;
      cyc();
      tests++;
      if (m_occ !== 2'd2 || m_in.ready !== 1'b0) begin
         fails++;
         $display("FAIL skid_full: got occ %0d rdy %b want 2 0",
                  m_occ, m_in.ready);
      end
      m_in.data = c;
      cyc();
      tests++;
      if (m_occ !== 2'd2 || m_out.data !== a || m_in.ready !== 1'b0) begin
         fails++;
         $display("FAIL skid_hold: got occ %0d data %h want 2 %h",
                  m_occ, m_out.data, a);
      end
      m_out.ready = 1'b1;
      cyc();
      tests++;
      if (m_out.data !== b || m_occ !== 2'd1) begin
         fails++;
         $display("FAIL skid_b: got %h occ %0d want %h 1",
                  m_out.data, m_occ, b);
      end
      cyc();
      tests++;
      if (m_out.data !== c || m_occ !== 2'd1) begin
         fails++;
         $display("FAIL skid_c: got %h occ %0d want %h 1",
                  m_out.data, m_occ, c);
      end
      m_in.valid = 1'b0;
      cyc();
      tests++;
      if (m_out.valid !== 1'b0 || m_occ !== 2'd0) begin
         fails++;
         $display("FAIL skid_empty: got %b occ %0d want 0 0",
                  m_out.valid, m_occ);
      end
   endtask

   task automatic test_flush_two();
      logic [DW-1:0] f;
      bit seen;
      f = rnd_data() | DW'(1);
      m_out.ready = 1'b0;
      m_in.valid = 1'b1;
      m_in.data = rnd_data();
      cyc();
      m_in.data = rnd_data();
      cyc();
      tests++;
      if (m_occ !== 2'd2) begin
         fails++;
         $display("FAIL flush_pre: got occ %0d want 2", m_occ);
      end
      m_flush = 1'b1;
      m_in.data = f;
      cyc();
      m_flush = 1'b0;
      m_in.valid = 1'b0;
      tests++;
      if (m_out.valid !== 1'b0 || m_out.data !== '0 || m_occ !== 2'd0) begin
         fails++;
         $display("FAIL flush_empty: got %b/%h occ %0d want 0/0 0",
                  m_out.valid, m_out.data, m_occ);
      end
      tests++;
      if (m_in.ready !== 1'b1) begin
         fails++;
         $display("FAIL flush_ready: got %b want 1", m_in.ready);
      end
      m_out.ready = 1'b1;
      seen = 1'b0;
      repeat (3) begin
         cyc();
         if (m_out.valid !== 1'b0) seen = 1'b1;
      end
      tests++;
      if (seen) begin
         fails++;
         $display("FAIL flush_lost: got a live output want none");
      end
   endtask

   task automatic test_bubble();
      int c0;
      m_in.valid = 1'b0;
      m_out.ready = 1'b1;
      c0 = mcnt;
      repeat (10) cyc();
      tests++;
      if (m_bub !== 16'(c0 + 10)) begin
         fails++;
         $display("FAIL bubble_10: got %0d want %0d", m_bub, c0 + 10);
      end
      t_out.ready = 1'b1;
      repeat (10) cyc();
      tests++;
      if (t_bub !== 4'd10) begin
         fails++;
         $display("FAIL bubble_sat10: got %0d want 10", t_bub);
      end
      repeat (10) cyc();
      tests++;
      if (t_bub !== 4'd15) begin
         fails++;
         $display("FAIL bubble_sat: got %0d want 15", t_bub);
      end
      t_out.ready = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         tests++;
         if (m_out.valid !== (mq.size() != 0) || m_out.data !== m_head()) begin
            fails++;
            if (fails < 20)
               $display("FAIL rnd_out[%0d]: got %b/%h want %b/%h", i,
                        m_out.valid, m_out.data, mq.size() != 0, m_head());
         end
         tests++;
         if (m_occ !== 2'(mq.size()) || m_in.ready !== (mq.size() < 2)) begin
            fails++;
            if (fails < 20)
               $display("FAIL rnd_occ[%0d]: got occ %0d rdy %b want %0d %b",
                        i, m_occ, m_in.ready, mq.size(), mq.size() < 2);
         end
         tests++;
         if (m_bub !== 16'(mcnt)) begin
            fails++;
            if (fails < 20)
               $display("FAIL rnd_bub[%0d]: got %0d want %0d", i, m_bub, mcnt);
         end
         m_in.valid = ($urandom_range(0, 3) != 0);
         m_in.data = rnd_data();
         if (i < 300) m_out.ready = ($urandom_range(0, 2) != 0);
         else m_out.ready = ($urandom_range(0, 2) == 0);
         m_flush = ($urandom_range(0, 29) == 0);
         cyc();
      end
      m_flush = 1'b0;
      m_in.valid = 1'b0;
      m_out.ready = 1'b0;
      cyc();
   endtask

   task automatic test_single();
      s_out.ready = 1'b0;
      s_in.valid = 1'b0;
      cyc();
      tests++;
      if (s_out.valid !== 1'b0 || s_out.data !== S_NOP ||
          s_in.ready !== 1'b1 || s_occ !== 2'd0) begin
         fails++;
         $display("FAIL single_idle: got %b/%h rdy %b occ %0d want 0/%h 1 0",
                  s_out.valid, s_out.data, s_in.ready, s_occ, S_NOP);
      end
      s_in.valid = 1'b1;
      s_in.data = 16'h0011;
      cyc();
      tests++;
      if (s_out.valid !== 1'b1 || s_out.data !== 16'h0011 ||
          s_occ !== 2'd1 || s_in.ready !== 1'b0) begin
         fails++;
         $display("FAIL single_full: got %b/%h occ %0d rdy %b want 1/0011 1 0",
                  s_out.valid, s_out.data, s_occ, s_in.ready);
      end
      s_out.ready = 1'b1;
      #1;
      tests++;
      if (s_in.ready !== 1'b1) begin
         fails++;
         $display("FAIL single_comb_hi: got %b want 1", s_in.ready);
      end
      s_out.ready = 1'b0;
      #1;
      tests++;
      if (s_in.ready !== 1'b0) begin
         fails++;
         $display("FAIL single_comb_lo: got %b want 0", s_in.ready);
      end
      s_in.data = 16'h0022;
      cyc();
      tests++;
      if (s_out.data !== 16'h0011 || s_occ !== 2'd1) begin
         fails++;
         $display("FAIL single_hold: got %h occ %0d want 0011 1",
                  s_out.data, s_occ);
      end
      s_out.ready = 1'b1;
      cyc();
      tests++;
      if (s_out.data !== 16'h0022 || s_occ !== 2'd1) begin
         fails++;
         $display("FAIL single_pass: got %h occ %0d want 0022 1",
                  s_out.data, s_occ);
      end
      s_in.valid = 1'b0;
      cyc();
      tests++;
      if (s_out.valid !== 1'b0 || s_out.data !== S_NOP || s_occ !== 2'd0) begin
         fails++;
         $display("FAIL single_clear: got %b/%h occ %0d want 0/%h 0",
                  s_out.valid, s_out.data, s_occ, S_NOP);
      end
   endtask

   task automatic test_random_single();
      logic [SW-1:0] sq[$];
      logic [SW-1:0] head;
      bit sv, acc, dep, rdy;
      for (int i = 0; i < 300; i++) begin
         s_in.valid = ($urandom_range(0, 2) != 0);
         s_in.data = 16'($urandom);
         s_out.ready = ($urandom_range(0, 1) != 0);
         s_flush = ($urandom_range(0, 24) == 0);
         #1;
         sv = (sq.size() != 0);
         head = sv ? sq[0] : S_NOP;
         rdy = !sv || s_out.ready;
         tests++;
         if (s_out.valid !== sv || s_out.data !== head ||
             s_occ !== 2'(sq.size()) || s_in.ready !== rdy) begin
            fails++;
            if (fails < 20)
               $display("FAIL srnd[%0d]: got %b/%h occ %0d rdy %b want %b/%h %0d %b",
                        i, s_out.valid, s_out.data, s_occ, s_in.ready,
                        sv, head, sq.size(), rdy);
         end
         acc = s_in.valid && rdy;
         dep = sv && s_out.ready;
         if (s_flush) begin
            sq.delete();
         end else begin
            if (dep) void'(sq.pop_front());
            if (acc) sq.push_back(s_in.data);
         end
         cyc();
      end
      s_flush = 1'b0;
      s_in.valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_skid();
      test_flush_two();
      test_bubble();
      test_random();
      test_single();
      test_random_single();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
